// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: divider state encoding, iteration
// count and the divide-by-zero quotient.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int          DIV_ITERS    = 32;
  localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFFFFFF;

  // Two's-complement negate when neg is set, otherwise pass the value through.
  function automatic logic [31:0] div_abs(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore the partial remainder.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             q_in,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {rem_in, q_in};
  assign diff    = shifted - {2'b00, divisor};
  // A clear sign bit means the trial subtraction did not underflow.
  assign q_bit   = ~diff[WIDTH+1];
  assign rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage: quotient to LO, remainder to HI,
// fixed 32-iteration latency with stall on busy until the done pulse.
module div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNT_W = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS - 1);

  div_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] bmag_reg;
  logic             sdiv_reg, qsign_reg, rsign_reg, bzero_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] lo_reg, hi_reg;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_next;
  logic             launch;

  // quo_reg starts as |a| and shifts left; its MSB feeds the remainder while
  // the new quotient bit enters at the bottom.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .divisor (bmag_reg),
    .q_in    (quo_reg[WIDTH-1]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign quo_next = {quo_reg[WIDTH-2:0], step_q};
  assign launch   = start && !annul;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (launch) state_next = RUN;
      RUN: begin
        if (annul)                  state_next = IDLE;
        else if (cnt_reg == LAST_CNT) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      bmag_reg  <= '0;
      sdiv_reg  <= 1'b0;
      qsign_reg <= 1'b0;
      rsign_reg <= 1'b0;
      bzero_reg <= 1'b0;
      lo_reg    <= '0;
      hi_reg    <= '0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
      case (state_reg)
        IDLE: begin
          if (launch) begin
            sdiv_reg  <= signed_div;
            qsign_reg <= a[WIDTH-1] ^ b[WIDTH-1];
            rsign_reg <= a[WIDTH-1];
            bzero_reg <= (b == '0);
            quo_reg   <= div_abs(a, signed_div & a[WIDTH-1]);
            bmag_reg  <= div_abs(b, signed_div & b[WIDTH-1]);
            rem_reg   <= '0;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          if (!annul) begin
            rem_reg <= step_rem;
            quo_reg <= quo_next;
            cnt_reg <= cnt_reg + 1'b1;
            // Results land on the final iteration so they are valid with done.
            if (cnt_reg == LAST_CNT) begin
              lo_reg <= bzero_reg ? DIV_ZERO_QUO
                                  : div_abs(quo_next, sdiv_reg & qsign_reg);
              hi_reg <= div_abs(step_rem[WIDTH-1:0], sdiv_reg & rsign_reg);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = (state_reg == DONE);
  assign lo   = lo_reg;
  assign hi   = hi_reg;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, annul/reset
// behaviour and randomized operands against an arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] lo;
  logic [31:0] hi;

  int checks_count   = 0;
  int failures_count = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .lo         (lo),
    .hi         (hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_count++;
    if (got !== exp) begin
      failures_count++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // MIPS semantics: truncating division, remainder takes the dividend sign,
  // divide-by-zero gives all-ones / dividend, overflow wraps.
  task automatic ref_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                         output logic [31:0] q, output logic [31:0] r);
    int sx, sy;
    if (y == 32'd0) begin
      q = 32'hFFFFFFFF;
      r = x;
    end else if (s) begin
      if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
        q = 32'h80000000;
        r = 32'd0;
      end else begin
        sx = x;
        sy = y;
        q  = sx / sy;
        r  = sx % sy;
      end
    end else begin
      q = x / y;
      r = x % y;
    end
  endtask

  // Launch one operation and watch it for a bounded window.
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic os,
                        input bit hold_start);
    logic [31:0] elo, ehi, glo, ghi;
    int busy_n, done_n, done_at;
    ref_div(oa, ob, os, elo, ehi);
    @(negedge clk);
    a = oa; b = ob; signed_div = os; start = 1'b1;
    @(posedge clk);
    #1;
    a = $urandom; b = $urandom; signed_div = ~os;
    if (!hold_start) start = 1'b0;
    busy_n = 0; done_n = 0; done_at = 0; glo = '0; ghi = '0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_n == 1) begin
          done_at = i;
          glo = lo;
          ghi = hi;
        end
        start = 1'b0;
      end
    end
    start = 1'b0;
    $display("op a=%h b=%h signed=%0d lo=%h hi=%h exp_lo=%h exp_hi=%h done_at=%0d",
             oa, ob, os, glo, ghi, elo, ehi, done_at);
    check("done_count", 32'(done_n), 32'd1);
    check("done_latency", 32'(done_at), 32'd33);
    check("busy_cycles", 32'(busy_n), 32'd33);
    check("lo", glo, elo);
    check("hi", ghi, ehi);
    check("lo_hold", lo, elo);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          done_n;
    resetn = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_hi", hi, 32'd0);
    resetn = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 1'b0);
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, 1'b0);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op(32'h00001234, 32'd0, 1'b0, 1'b0);
    run_op(32'hFFFFFF00, 32'd0, 1'b1, 1'b0);
    run_op(32'h80000000, 32'd1, 1'b0, 1'b0);

    // Annul in the middle of a run: no done, no result update.
    run_op(32'd50, 32'd5, 1'b0, 1'b0);
    @(negedge clk);
    a = 32'd9; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1 annul = 1'b0;
    @(negedge clk);
    check("annul_busy", 32'(busy), 32'd0);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    $display("annul a=9 b=3 lo=%h hi=%h dones=%0d", lo, hi, done_n);
    check("annul_no_done", 32'(done_n), 32'd0);
    check("annul_lo", lo, 32'd10);
    check("annul_hi", hi, 32'd0);
    run_op(32'd9, 32'd3, 1'b0, 1'b0);

    // start together with annul in IDLE must not launch.
    @(negedge clk);
    a = 32'd8; b = 32'd2; start = 1'b1; annul = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; annul = 1'b0;
    @(negedge clk);
    $display("start+annul busy=%0d", busy);
    check("start_annul_busy", 32'(busy), 32'd0);

    // start held high throughout: exactly one result, first operands.
    run_op(32'd1000, 32'd7, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    $display("reset mid-run busy=%0d done=%0d lo=%h hi=%h", busy, done, lo, hi);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_hi", hi, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op(32'd81, 32'd9, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(0, 15));
        2:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(ra, rb, rs, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_count, failures_count);
    $finish;
  end

endmodule
